// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the time-multiplexed S-box lane.
// Imported by the lane, the scheduler and its handshake interface.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic SC_FWD  = 1'b0;
    localparam logic SC_INV  = 1'b1;
    localparam int   BLOCK_W = 128;
    localparam int   WORD_W  = 32;

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int i = 0; i < 7; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] i;
        i = gf_inv(a);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3)
                 ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

endpackage

// File: rtl/sbox_lane_sched_if.sv
// Request/response handshake bundle between the requesters and the
// lane scheduler: 128-bit state path plus the SubWord key path.
interface sbox_lane_sched_if;
    import aes_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] in_data;
    logic               in_sc;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] out_data;
    logic               key_valid;
    logic               key_ready;
    logic [WORD_W-1:0]  key_word;
    logic               key_out_valid;
    logic [WORD_W-1:0]  key_out;

    modport master (
        output in_valid, in_data, in_sc, out_ready, key_valid, key_word,
        input  in_ready, out_valid, out_data, key_ready,
               key_out_valid, key_out
    );

    modport slave (
        input  in_valid, in_data, in_sc, out_ready, key_valid, key_word,
        output in_ready, out_valid, out_data, key_ready,
               key_out_valid, key_out
    );

endinterface

// File: rtl/sbox_word.sv
// Combinational 32-bit S-box lane: four byte S-boxes sharing one
// forward/inverse select, built from GF(2^8) inversion plus affine maps.
module sbox_byte
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    input  logic       i_sc,
    output logic [7:0] o_byte
);

    assign o_byte = (i_sc == SC_INV) ? sbox_inv(i_byte) : sbox_fwd(i_byte);

endmodule

module sbox_word
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_sc,
    output logic [WORD_W-1:0] o_word
);

    for (genvar g = 0; g < 4; g++) begin : g_byte
        sbox_byte u_sbox (
            .i_byte (i_word[8*g +: 8]),
            .i_sc   (i_sc),
            .o_byte (o_word[8*g +: 8])
        );
    end

endmodule

// File: rtl/sbox_lane_sched.sv
// Cycle-by-cycle arbiter sharing one 32-bit S-box lane between the
// 4-beat state path and 1-beat SubWord. Option: SBOX_SCHED_STALL_CNT_EN.
module sbox_lane_sched
    import aes_pkg::*;
#(
    parameter int BEATS = 4
`ifdef SBOX_SCHED_STALL_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    sbox_lane_sched_if.slave  bus,
    output logic [WORD_W-1:0] lane_in,
    output logic              lane_sc,
    input  logic [WORD_W-1:0] lane_out
`ifdef SBOX_SCHED_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    localparam int BEAT_W = $clog2(BEATS);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BEAT_W-1:0]  r_beat;
    logic               r_last_key;
    logic               r_sc;
    logic [BLOCK_W-1:0] r_held;
    logic [BLOCK_W-1:0] r_res;
    logic               r_key_vld;
    logic [WORD_W-1:0]  r_key_out;

    logic w_key_gnt;
    logic w_beat_go;
    logic w_accept;
    logic w_last_beat;

    // key wins, except it may not take two DATA cycles in a row
    assign w_key_gnt   = bus.key_valid & ((r_state != DATA) | ~r_last_key);
    assign w_beat_go   = (r_state == DATA) & ~w_key_gnt;
    assign w_accept    = bus.in_valid & bus.in_ready;
    assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));

    assign bus.in_ready      = (r_state == IDLE);
    assign bus.out_valid     = (r_state == DONE);
    assign bus.out_data      = r_res;
    assign bus.key_ready     = w_key_gnt;
    assign bus.key_out_valid = r_key_vld;
    assign bus.key_out       = r_key_out;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_nxt = DATA;
            DATA:    if (w_beat_go && w_last_beat) w_state_nxt = DONE;
            DONE:    if (bus.out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        lane_in = '0;
        lane_sc = SC_FWD;
        unique case (1'b1)
            w_key_gnt: lane_in = bus.key_word;
            w_beat_go: begin
                lane_in = r_held[r_beat*WORD_W +: WORD_W];
                lane_sc = r_sc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_beat     <= '0;
            r_last_key <= 1'b0;
            r_sc       <= SC_FWD;
            r_held     <= '0;
            r_res      <= '0;
            r_key_vld  <= 1'b0;
            r_key_out  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_last_key <= w_key_gnt;
            r_key_vld  <= w_key_gnt;
            if (w_key_gnt) r_key_out <= lane_out;
            if (w_accept) begin
                r_held <= bus.in_data;
                r_sc   <= bus.in_sc;
                r_beat <= '0;
            end
            if (w_beat_go) begin
                r_res[r_beat*WORD_W +: WORD_W] <= lane_out;
                r_beat <= r_beat + 1'b1;
            end
        end
    end

`ifdef SBOX_SCHED_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
        end else if (r_state == DATA && w_key_gnt && r_stall != '1) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_sbox_lane_sched.sv
// Bench for sbox_lane_sched with the real lane; S-box tables are rebuilt
// here from generator-3 log/antilog walks, independent of the RTL maths.
module tb_sbox_lane_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sbox_lane_sched_if bus();
    logic [31:0] lane_in;
    logic [31:0] lane_out;
    logic        lane_sc;
`ifdef SBOX_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    sbox_lane_sched dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .lane_in  (lane_in),
        .lane_sc  (lane_sc),
        .lane_out (lane_out)
`ifdef SBOX_SCHED_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    sbox_word u_lane (
        .i_word (lane_in),
        .i_sc   (lane_sc),
        .o_word (lane_out)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] fwd [256];
    logic [7:0] inv [256];
    logic prev_dg = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w, input logic sc);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = sc ? inv[w[8*i +: 8]] : fwd[w[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] subb(input logic [127:0] d, input logic sc);
        logic [127:0] r;
        for (int i = 0; i < 4; i++)
            r[32*i +: 32] = subw(d[32*i +: 32], sc);
        return r;
    endfunction

    // one clock: also scores the key path and the no-double-key rule
    task automatic step();
        logic kr, r, busy;
        logic [31:0] kw;
        #1;
        kr   = bus.key_ready;
        kw   = bus.key_word;
        r    = rst;
        busy = !bus.in_ready && !bus.out_valid;
        total++;
        assert (!(busy && kr && prev_dg && !r)) else begin
            bad++;
            $error("FAIL key_twice got=1 exp=0");
        end
        prev_dg = busy && kr && !r;
        @(posedge clk);
        #1;
        chk("key_out_valid", 128'(bus.key_out_valid), 128'(kr && !r));
        if (kr && !r) chk("key_out", 128'(bus.key_out), 128'(subw(kw, 1'b0)));
    endtask

    task automatic do_block(input logic [127:0] d, input logic sc,
                            input int kprob, input bit key_at_accept,
                            input int hold, input int exp_grants,
                            output logic [127:0] got);
        int lat, grants;
        logic [127:0] exp;
        exp = subb(d, sc);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_sc     = sc;
        bus.out_ready = 1'b0;
        bus.key_valid = key_at_accept && ($urandom_range(99) < kprob);
        bus.key_word  = $urandom;
        #1;
        chk("accept_ready", 128'(bus.in_ready), 128'(1'b1));
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
        lat = 1;
        grants = 0;
        while (lat < 40) begin
            bus.key_valid = ($urandom_range(99) < kprob);
            bus.key_word  = $urandom;
            #1;
            if (bus.out_valid) break;
            if (bus.key_ready) grants++;
            step();
            lat++;
        end
        got = bus.out_data;
        chk("latency", 128'(lat), 128'(5 + grants));
        if (exp_grants >= 0) chk("grants", 128'(grants), 128'(exp_grants));
        chk("out_data", bus.out_data, exp);
        bus.in_valid = 1'b1;
        bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", 128'(bus.out_valid), 128'(1'b1));
            chk("hold_data", bus.out_data, exp);
            chk("hold_in_ready", 128'(bus.in_ready), 128'(1'b0));
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.key_valid = 1'b0;
        #1;
        chk("idle_ready", 128'(bus.in_ready), 128'(1'b1));
        chk("idle_valid", 128'(bus.out_valid), 128'(1'b0));
    endtask

    initial begin
        logic [7:0] p, q, x;
        logic [127:0] got;
        logic [127:0] d;

        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]}
                  ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            fwd[p] = x ^ 8'h63;
        end while (p != 8'h01);
        fwd[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv[fwd[i]] = 8'(i);

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sc     = 1'b0;
        bus.out_ready = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_word  = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1'b1));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
        chk("rst_out_data", bus.out_data, 128'h0);
        chk("rst_key_vld", 128'(bus.key_out_valid), 128'(1'b0));
        chk("rst_key_out", 128'(bus.key_out), 128'h0);

        do_block(128'h00112233445566778899aabbccddeeff, 1'b0, 0, 1'b0, 0, 0, got);
        chk("fwd_vector", got, 128'h638293c31bfc33f5c4eeacea4bc12816);
        do_block(128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, 0, 1'b0, 0, 0, got);
        chk("inv_vector", got, 128'h00112233445566778899aabbccddeeff);

        bus.key_valid = 1'b1;
        bus.key_word  = 32'h00000053;
        #1;
        chk("key_idle_ready", 128'(bus.key_ready), 128'(1'b1));
        step();
        bus.key_valid = 1'b0;
        chk("key_idle_out", 128'(bus.key_out), 128'h636363ed);
        step();
        chk("key_pulse_end", 128'(bus.key_out_valid), 128'(1'b0));

        do_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 100, 1'b0,
                 0, 4, got);
`ifdef SBOX_SCHED_STALL_CNT_EN
        chk("stall_cnt", 128'(stall_cnt), 128'd4);
`endif

        do_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, 0, 1'b0,
                 10, 0, got);

        d = {$urandom, $urandom, $urandom, $urandom};
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sc    = 1'b0;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        rst           = 1'b1;
        bus.key_valid = 1'b1;
        bus.key_word  = $urandom;
        step();
        rst           = 1'b0;
        bus.key_valid = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(bus.out_valid), 128'(1'b0));
        chk("mid_rst_ready", 128'(bus.in_ready), 128'(1'b1));
        chk("mid_rst_kvld", 128'(bus.key_out_valid), 128'(1'b0));
        chk("mid_rst_data", bus.out_data, 128'h0);
`ifdef SBOX_SCHED_STALL_CNT_EN
        chk("mid_rst_stall", 128'(stall_cnt), 128'd0);
`endif

        for (int n = 0; n < 20; n++) begin
            do_block({$urandom, $urandom, $urandom, $urandom},
                     1'($urandom_range(1)), 40, 1'b1,
                     int'($urandom_range(3)), -1, got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sbox_lane_sched.md
Name: sbox_lane_sched

Overview:
- Time-multiplexes one shared 32-bit S-box lane (4 byte S-boxes, common sc select) between two requesters:
  - the 128-bit state datapath (SubBytes / InvSubBytes, 4 beats);
  - the key-expansion SubWord path (1 beat, always forward S-box).
- Replaces a 16-S-box full-width bank with a 4-S-box lane plus this scheduler.
- The lane is combinational. The scheduler drives its input and sc, captures its output, and arbitrates cycle by cycle.

Parameters:
- BEATS, 4, lane beats per 128-bit block (fixed at 4; 32 bits per beat).
- CNT_W, 16, width of the optional stall counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  data request valid.
- in_ready  out  1  scheduler can accept a data request.
- in_data  in  128  state to substitute.
- in_sc  in  1  0 = forward S-box, 1 = inverse S-box.
- out_valid  out  1  substituted state valid.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  128  substituted state.
- key_valid  in  1  SubWord request.
- key_ready  out  1  SubWord granted this cycle.
- key_word  in  32  word to substitute.
- key_out_valid  out  1  one-cycle pulse, cycle after grant.
- key_out  out  32  SubWord result.
- lane_in  out  32  to shared S-box lane.
- lane_sc  out  1  to shared S-box lane.
- lane_out  in  32  from shared S-box lane, same-cycle.

Behaviour:
- Reset values (rst sampled high at clk edge, including mid-operation):
  - state = IDLE; beat counter = 0; last_key = 0.
  - out_valid = 0, out_data = 0, key_out_valid = 0, key_out = 0.
  - Any in-flight block is discarded.
- in_ready is 1 only in IDLE.
- FSM states:
  - IDLE: in_valid & in_ready latches in_data and in_sc, clears beat = 0, goes to DATA.
  - DATA: each cycle the lane goes to either a data beat or a key grant.
    - On a data beat: lane_in = held[32*beat+31:32*beat], lane_sc = held sc; lane_out is written into the result register at the same slice; beat increments.
    - After beat 3 completes, go to DONE.
  - DONE: out_valid = 1; out_data holds the result, stable until out_ready. out_valid & out_ready returns to IDLE. in_ready = 0 in DONE, so no bypass of the same cycle.
- Arbitration:
  - key_ready = key_valid & ((state != DATA) | ~last_key).
  - last_key registers whether the previous cycle granted key. Key has priority but cannot take two consecutive DATA cycles, so a data beat gets at least every second cycle.
  - On key grant: lane_in = key_word, lane_sc = 0. Next cycle key_out = lane_out and key_out_valid = 1 for exactly one cycle; key path has no backpressure.
  - When lane is idle (no grant): lane_in = 0, lane_sc = 0.
- Latency:
  - Data, no key traffic: accept at T, beats T+1..T+4, out_valid at T+5.
  - Each interleaved key grant adds 1 cycle.
  - Key: result 1 cycle after grant, in any state.
- Simultaneous events:
  - key_valid in the IDLE accept cycle: both granted.
  - key_valid in DONE: granted.
  - in_valid while busy: held off via in_ready = 0.
- Beat counter: 2 bits; wrap from 3 exits DATA.

Optional Feature:
- Macro SBOX_SCHED_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [CNT_W-1:0].
  - Counts cycles in DATA in which the lane was granted to key.
  - Saturates at all-ones; cleared by rst; never wraps.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package (aes_pkg):
  - FSM state enum IDLE/DATA/DONE;
  - SC_FWD = 0, SC_INV = 1;
  - BLOCK_W = 128, WORD_W = 32.
- The lane itself is the natural sub-module, sbox_word: 4 S-box instances with common sc, instantiated alongside the scheduler by the parent.
- Scheduler contains no S-box tables.

Test Plan:
- Forward block, no key traffic: in_data = 0x00112233445566778899aabbccddeeff, sc = 0 → out_data = 0x638293c31bfc33f5c4eeacea4bc12816, out_valid exactly 5 cycles after accept.
- Inverse round-trip: feed 0x638293c31bfc33f5c4eeacea4bc12816 with sc = 1 → 0x00112233445566778899aabbccddeeff.
- Key in IDLE: key_word = 0x00000053 → key_ready same cycle; next cycle key_out = 0x636363ED, single-cycle key_out_valid pulse.
- Contention: key_valid held high for the whole block → grants alternate key/data; data out_valid at T+9; out_data still correct; no two consecutive key grants in DATA.
- Backpressure then reset: hold out_ready = 0 for 10 cycles → out_valid and out_data stable, in_ready = 0; assert rst mid-DATA in a second block → next cycle out_valid = 0, in_ready = 1, key_out_valid = 0.
- With SBOX_SCHED_STALL_CNT_EN defined: contention scenario → stall_cnt = 4 after one block.
